// File: rtl/edp_diag_pkg.sv
// Shared EBUS diagnostic definitions: read-function code, source codes,
// reader state encoding and the diag word builder.
package edp_diag_pkg;

  localparam logic [3:0] DIAG_READ_FUNC = 4'b0101;

  localparam logic [2:0] SRC_AR  = 3'd0;
  localparam logic [2:0] SRC_BR  = 3'd1;
  localparam logic [2:0] SRC_MQ  = 3'd2;
  localparam logic [2:0] SRC_FM  = 3'd3;
  localparam logic [2:0] SRC_BRX = 3'd4;
  localparam logic [2:0] SRC_ARX = 3'd5;
  localparam logic [2:0] SRC_ADX = 3'd6;
  localparam logic [2:0] SRC_AD  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  // diag[0:3] = read function, diag[4:6] = source, diag[7:8] = 0
  function automatic logic [0:8] diag_word(input logic [2:0] src);
    return {DIAG_READ_FUNC, src, 2'b00};
  endfunction

endpackage

// File: rtl/ebus_diag_reader.sv
// Reads one or all eight data-path sources over EBUS via the diag function,
// waiting SETTLE cycles before sampling and returning each word by handshake.
module ebus_diag_reader
  import edp_diag_pkg::*;
#(
  parameter int unsigned SETTLE = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqScan,
  input  logic [0:2]  reqSel,
  input  logic        abort,
  input  logic [0:35] ebusD,
  output logic [0:8]  diag,
  output logic        diagReadFunc12X,
  output logic        rspValid,
  input  logic        rspReady,
  output logic [0:35] rspData,
  output logic [0:2]  rspSel,
  output logic        rspLast,
  output logic        busy
);

  localparam logic [3:0] SETTLE_CNT = SETTLE[3:0];

  state_t     state;
  logic       scan;
  logic [2:0] src;
  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      scan            <= 1'b0;
      src             <= '0;
      cnt             <= '0;
      reqReady        <= 1'b1;
      busy            <= 1'b0;
      diag            <= '0;
      diagReadFunc12X <= 1'b0;
      rspValid        <= 1'b0;
      rspData         <= '0;
      rspSel          <= '0;
      rspLast         <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (reqValid) begin
            scan            <= reqScan;
            src             <= reqScan ? SRC_AR : reqSel;
            cnt             <= SETTLE_CNT;
            diag            <= diag_word(reqScan ? SRC_AR : reqSel);
            diagReadFunc12X <= 1'b1;
            reqReady        <= 1'b0;
            busy            <= 1'b1;
            state           <= ST_DRIVE;
          end
        end

        ST_DRIVE: begin
          if (abort) begin
            state           <= ST_IDLE;
            cnt             <= '0;
            diag            <= '0;
            diagReadFunc12X <= 1'b0;
            reqReady        <= 1'b1;
            busy            <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
              rspData         <= ebusD;
              rspSel          <= src;
              rspLast         <= !scan || (src == SRC_AD);
              rspValid        <= 1'b1;
              diag            <= '0;
              diagReadFunc12X <= 1'b0;
              state           <= ST_RESP;
            end
          end
        end

        ST_RESP: begin
          // abort takes priority: a word offered with rspReady is dropped
          if (abort) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            rspValid <= 1'b0;
            reqReady <= 1'b1;
            busy     <= 1'b0;
          end else if (rspReady) begin
            rspValid <= 1'b0;
            if (rspLast) begin
              state    <= ST_IDLE;
              reqReady <= 1'b1;
              busy     <= 1'b0;
            end else begin
              src             <= src + 3'd1;
              cnt             <= SETTLE_CNT;
              diag            <= diag_word(src + 3'd1);
              diagReadFunc12X <= 1'b1;
              state           <= ST_DRIVE;
            end
          end
        end

        default: begin
          state           <= ST_IDLE;
          cnt             <= '0;
          diag            <= '0;
          diagReadFunc12X <= 1'b0;
          rspValid        <= 1'b0;
          reqReady        <= 1'b1;
          busy            <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ebus_diag_reader.sv
// Directed scoreboard bench for ebus_diag_reader (SETTLE=2 main instance,
// SETTLE=1 instance for back-to-back single reads).
module tb_ebus_diag_reader;

  typedef struct packed {
    logic [35:0] d;
    logic [2:0]  s;
    logic        l;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        req_valid = 1'b0, req_scan = 1'b0, abort = 1'b0, rsp_ready = 1'b0;
  logic [0:2]  req_sel = '0;
  logic [0:35] ebus_d, ebus_fixed = '0;
  logic        ebus_model = 1'b0;
  logic        req_ready, diag_func, rsp_valid, rsp_last, busy;
  logic [0:8]  diag;
  logic [0:35] rsp_data;
  logic [0:2]  rsp_sel;

  logic        v1 = 1'b0;
  logic        ready1_in = 1'b1;
  logic [0:35] ebus1 = 36'o707070707070;
  logic        req_ready1, diag_func1, rsp_valid1, rsp_last1, busy1;
  logic [0:8]  diag1;
  logic [0:35] rsp_data1;
  logic [0:2]  rsp_sel1;

  int   checks = 0;
  int   fails = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  // data-path model: drives each source's index replicated while enabled
  always_comb begin
    ebus_d = ebus_fixed;
    if (ebus_model) ebus_d = diag_func ? {12{diag[4:6]}} : '0;
  end

  ebus_diag_reader #(.SETTLE(2)) u_dut (
    .clk(clk), .reset(reset), .reqValid(req_valid), .reqReady(req_ready),
    .reqScan(req_scan), .reqSel(req_sel), .abort(abort), .ebusD(ebus_d),
    .diag(diag), .diagReadFunc12X(diag_func), .rspValid(rsp_valid),
    .rspReady(rsp_ready), .rspData(rsp_data), .rspSel(rsp_sel),
    .rspLast(rsp_last), .busy(busy)
  );

  ebus_diag_reader #(.SETTLE(1)) u_dut1 (
    .clk(clk), .reset(reset), .reqValid(v1), .reqReady(req_ready1),
    .reqScan(1'b0), .reqSel(3'd3), .abort(1'b0), .ebusD(ebus1),
    .diag(diag1), .diagReadFunc12X(diag_func1), .rspValid(rsp_valid1),
    .rspReady(ready1_in), .rspData(rsp_data1), .rspSel(rsp_sel1),
    .rspLast(rsp_last1), .busy(busy1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(input logic [2:0] sel);
    int k = 0;
    while (!(rsp_valid && rsp_sel == sel) && k < 60) begin
      tick();
      k++;
    end
    chk("wait_rsp_timeout", 64'(k < 60), 64'd1);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 100) begin
      tick();
      k++;
    end
    chk("wait_idle_timeout", 64'(k < 100), 64'd1);
  endtask

  // scoreboard: a word is taken when offered with rspReady and not killed
  always @(negedge clk) begin
    if (!reset && rsp_valid && rsp_ready && !abort) begin
      checks++;
      assert (q.size() != 0) else begin
        fails++;
        $error("FAIL unexpected_rsp: observed sel %0d expected none", rsp_sel);
      end
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        chk("sb_data", 64'(rsp_data), 64'(e.d));
        chk("sb_sel", 64'(rsp_sel), 64'(e.s));
        chk("sb_last", 64'(rsp_last), 64'(e.l));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1);
  end

  initial begin
    int n;
    logic [0:35] word;

    // reset
    tick(); tick();
    reset = 1'b0;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_diag", 64'(diag), 64'd0);
    chk("rst_func", 64'(diag_func), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);

    // single read of ARX
    word = 36'o123456701234;
    ebus_fixed = word;
    req_valid = 1'b1; req_scan = 1'b0; req_sel = 3'd5;
    q.push_back('{d: word, s: 3'd5, l: 1'b1});
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("single_diag", 64'(diag), 64'(9'b0101_101_00));
      chk("single_func", 64'(diag_func), 64'd1);
      chk("single_no_rsp", 64'(rsp_valid), 64'd0);
      tick();
    end
    chk("single_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("single_resp_diag", 64'(diag), 64'd0);
    chk("single_resp_func", 64'(diag_func), 64'd0);
    chk("single_data", 64'(rsp_data), 64'(word));
    chk("single_sel", 64'(rsp_sel), 64'd5);
    chk("single_last", 64'(rsp_last), 64'd1);
    rsp_ready = 1'b1;
    tick();
    chk("single_done_busy", 64'(busy), 64'd0);
    chk("single_done_ready", 64'(req_ready), 64'd1);
    chk("single_done_valid", 64'(rsp_valid), 64'd0);

    // full scan, consumer always ready
    ebus_model = 1'b1;
    for (int i = 0; i < 8; i++)
      q.push_back('{d: {12{3'(i)}}, s: 3'(i), l: (i == 7)});
    req_valid = 1'b1; req_scan = 1'b1;
    tick();
    req_valid = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    chk("scan_cycles", 64'(n), 64'd24);
    chk("scan_sb_empty", 64'(q.size()), 64'd0);
    chk("scan_idle_ready", 64'(req_ready), 64'd1);

    // scan with a 5-cycle stall on word 3
    for (int i = 0; i < 8; i++)
      q.push_back('{d: {12{3'(i)}}, s: 3'(i), l: (i == 7)});
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    wait_rsp(3'd3);
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", 64'(rsp_valid), 64'd1);
      chk("stall_sel", 64'(rsp_sel), 64'd3);
      chk("stall_data", 64'(rsp_data), 64'(36'o333333333333));
      chk("stall_diag", 64'(diag), 64'd0);
      chk("stall_func", 64'(diag_func), 64'd0);
    end
    rsp_ready = 1'b1;
    tick();
    chk("resume_func", 64'(diag_func), 64'd1);
    chk("resume_diag", 64'(diag), 64'(9'b0101_100_00));
    wait_idle();
    chk("stall_sb_empty", 64'(q.size()), 64'd0);

    // abort during DRIVE of source 2
    q.push_back('{d: {12{3'd0}}, s: 3'd0, l: 1'b0});
    q.push_back('{d: {12{3'd1}}, s: 3'd1, l: 1'b0});
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    n = 0;
    while (!(diag_func && diag[4:6] == 3'd2) && n < 60) begin
      tick();
      n++;
    end
    chk("abort_wait_timeout", 64'(n < 60), 64'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_req_ready", 64'(req_ready), 64'd1);
    chk("abort_func", 64'(diag_func), 64'd0);
    chk("abort_diag", 64'(diag), 64'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("abort_no_rsp", 64'(rsp_valid), 64'd0);
    end
    chk("abort_sb_empty", 64'(q.size()), 64'd0);

    // abort in IDLE ignored; abort beats handshake in RESP
    ebus_model = 1'b0;
    ebus_fixed = 36'o765432107654;
    rsp_ready = 1'b0; req_scan = 1'b0; req_sel = 3'd6;
    req_valid = 1'b1; abort = 1'b1;
    tick();
    req_valid = 1'b0; abort = 1'b0;
    chk("idle_abort_busy", 64'(busy), 64'd1);
    chk("idle_abort_diag", 64'(diag), 64'(9'b0101_110_00));
    wait_rsp(3'd6);
    rsp_ready = 1'b1; abort = 1'b1;
    tick();
    abort = 1'b0; rsp_ready = 1'b0;
    chk("abort_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("abort_rsp_busy", 64'(busy), 64'd0);
    chk("abort_rsp_sb", 64'(q.size()), 64'd0);

    // reset during RESP with rspReady high
    ebus_fixed = 36'o111122223333;
    req_sel = 3'd1; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    wait_rsp(3'd1);
    chk("prerst_data", 64'(rsp_data), 64'(36'o111122223333));
    rsp_ready = 1'b1; reset = 1'b1;
    tick();
    reset = 1'b0; rsp_ready = 1'b0;
    chk("mrst_valid", 64'(rsp_valid), 64'd0);
    chk("mrst_data", 64'(rsp_data), 64'd0);
    chk("mrst_sel", 64'(rsp_sel), 64'd0);
    chk("mrst_last", 64'(rsp_last), 64'd0);
    chk("mrst_diag", 64'(diag), 64'd0);
    chk("mrst_func", 64'(diag_func), 64'd0);
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_req_ready", 64'(req_ready), 64'd1);
    chk("mrst_sb", 64'(q.size()), 64'd0);

    // SETTLE=1, reqValid held: one response every 3 cycles
    v1 = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk("b2b_valid", 64'(rsp_valid1), 64'((i % 3) == 2));
      chk("b2b_busy", 64'(busy1), 64'((i % 3) != 0));
      if (i % 3 == 2) begin
        chk("b2b_data", 64'(rsp_data1), 64'(36'o707070707070));
        chk("b2b_sel", 64'(rsp_sel1), 64'd3);
      end
    end
    v1 = 1'b0;

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/ebus_diag_reader.md
EBUS_DIAG_READER -- requirements
Module: ebus_diag_reader

Interface
REQ-001 SETTLE, default 2, EBUS settle cycles from diag function drive to ebusD sample; legal 1..15.
REQ-002 clk  in  1  sole clock; all state changes on posedge clk.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 reqValid  in  1  read request present.
REQ-005 reqReady  out  1  request accepted when reqValid & reqReady at posedge.
REQ-006 reqScan  in  1  1 = read all eight sources 0..7; 0 = single source.
REQ-007 reqSel  in  [0:2]  source for single read: 0 AR, 1 BR, 2 MQ, 3 FM, 4 BRX, 5 ARX, 6 ADX, 7 AD.
REQ-008 abort  in  1  cancel current operation.
REQ-009 ebusD  in  [0:35]  EBUS data driven by the data path.
REQ-010 diag  out  [0:8]  diag function: [0:3] read-function code, [4:6] source select, [7:8] zero.
REQ-011 diagReadFunc12X  out  1  enables data path drive of ebusD.
REQ-012 rspValid  out  1  response word available.
REQ-013 rspReady  in  1  consumer takes word when rspValid & rspReady at posedge.
REQ-014 rspData  out  [0:35]  captured ebusD.
REQ-015 rspSel  out  [0:2]  source of rspData.
REQ-016 rspLast  out  1  final word of operation (always 1 for single; 1 on source 7 for scan).
REQ-017 busy  out  1  high in any state other than IDLE.

Function
REQ-018 States IDLE, DRIVE, RESP; reqReady = 1 only in IDLE.
REQ-019 IDLE: on reqValid, latch reqScan, load current source = reqScan ? 0 : reqSel, load settle counter = SETTLE, enter DRIVE.
REQ-020 DRIVE: diagReadFunc12X = 1, diag[4:6] = current source, diag[0:3] = DIAG_READ_FUNC; counter decrements each cycle.
REQ-021 DRIVE with counter = 1 at posedge: rspData <= ebusD, rspSel <= source, rspLast set per REQ-016, enter RESP; rspValid high exactly SETTLE posedges after acceptance edge.
REQ-022 RESP: rspValid = 1, diagReadFunc12X = 0, diag = 0; rspData/rspSel/rspLast stable until handshake.
REQ-023 RESP handshake, rspLast = 1: enter IDLE; reqReady first high the cycle after, so back-to-back requests have one idle cycle.
REQ-024 RESP handshake, rspLast = 0 (scan): source increments, counter reloads SETTLE, enter DRIVE.
REQ-025 Source increment never wraps: scan issues exactly eight responses 0..7 in order.
REQ-026 Outside DRIVE, diag = 0 and diagReadFunc12X = 0.
REQ-027 abort in DRIVE or RESP: next posedge enters IDLE, rspValid drops, no further responses; abort wins over a simultaneous rspReady handshake (word counted as not taken); abort in IDLE ignored, and reqValid accepted normally.
REQ-028 rspReady outside RESP ignored; reqValid outside IDLE ignored (not latched).

Reset
REQ-029 reset at any time, mid-operation included: next posedge state IDLE, rspValid 0, rspData 0, rspSel 0, rspLast 0, diag 0, diagReadFunc12X 0, busy 0, counter 0; reset overrides abort and reqValid.

Structure
REQ-030 Shared package edp_diag_pkg holds DIAG_READ_FUNC (4'b0101), source codes SRC_AR..SRC_AD (3-bit), and state encoding.
REQ-031 Single flat module; no sub-module.

Verification
REQ-032 Single read, SETTLE=2, reqSel=5, ebusD=36'o123456701234 from acceptance -> diag[4:6]=5 and diagReadFunc12X high 2 cycles, rspValid at edge +2, rspData=36'o123456701234, rspSel=5, rspLast=1.
REQ-033 Scan, ebusD modelled as source index replicated, rspReady held 1 -> eight words sel 0..7 in order, rspLast only on 7, total 8*(SETTLE+1) cycles, then IDLE.
REQ-034 Scan with rspReady low 5 cycles on word 3 -> rspData/rspSel frozen, diag=0 during stall, scan resumes with source 4.
REQ-035 abort in DRIVE of source 2 during scan -> IDLE next edge, no response for 2, reqReady 1 next cycle.
REQ-036 reset asserted in RESP with rspReady=1 same cycle -> no handshake credited, all outputs per REQ-029 next edge.
REQ-037 SETTLE=1 single read, reqValid held high continuously -> responses every 3 cycles with rspReady=1; reqValid during busy not double-accepted.
